ext_r_responder_ipa: RTL
========================

EXT_R_RESPONDER_IPA -- requirements
Module: ext_r_responder_ipa

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, R data and memory width; legal values 32, 64 or 128.
REQ-004 SHALL have parameter USER_WIDTH, default 6, AXI user width.
REQ-005 SHALL have one clock and a synchronous, active-high reset; all logic on the rising edge of clk_i.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 ar_valid_i / ar_ready_o  in/out  1 each  AR handshake.
REQ-009 ar_id_i  in  ID_WIDTH;  ar_user_i  in  USER_WIDTH;  ar_addr_i  in  ADDR_WIDTH.
REQ-010 ar_len_i  in  8  (beats-1);  ar_size_i  in  3;  ar_burst_i  in  2.
REQ-011 mem_req_o  out  1;  mem_gnt_i  in  1;  mem_addr_o  out  ADDR_WIDTH  bus-aligned word address.
REQ-012 mem_rvalid_i  in  1;  mem_rdata_i  in  DATA_WIDTH;  mem_err_i  in  1  (valid with mem_rvalid_i).
REQ-013 r_valid_o  out  1;  r_ready_i  in  1;  r_data_o  out  DATA_WIDTH;  r_resp_o  out  2;  r_id_o  out  ID_WIDTH;  r_user_o  out  USER_WIDTH;  r_last_o  out  1.

Function
REQ-014 FSM states: IDLE, ISSUE, ERR; ar_ready_o SHALL be 1 only in IDLE; AR accepted when ar_valid_i & ar_ready_o.
REQ-015 On accept: latch id, user, addr, len, size, burst; beat counter = 0; go to ERR if burst = 2'b11, or 2^size > DATA_WIDTH/8, or burst = WRAP with len not in {1,3,7,15}, else ISSUE.
REQ-016 ISSUE: mem_req_o = 1 when credit > 0; credit = 2 - (fifo_count + outstanding); beat issued on mem_req_o & mem_gnt_i.
REQ-017 mem_addr_o SHALL be the current beat address with the low log2(DATA_WIDTH/8) bits zeroed.
REQ-018 Beat address: FIXED (00) constant; INCR (01) next = aligned(addr, 2^size) + 2^size; WRAP (10) wraps within a (len+1)*2^size aligned window; arithmetic modulo 2^ADDR_WIDTH.
REQ-019 After the granted beat with counter = len: return to IDLE the same edge; outstanding responses still complete.
REQ-020 Memory responses in order, latency >= 1 cycle after grant; each mem_rvalid_i pushes {id, user, data, resp, last} into the response FIFO; resp = 2'b10 (SLVERR) if mem_err_i else 2'b00.
REQ-021 ERR: no memory access; push len+1 beats, data 0, resp SLVERR, last on final beat, one push per cycle when FIFO not full; then IDLE.
REQ-022 Response FIFO: 2 entries; r_valid_o = not empty; pop on r_valid_o & r_ready_i; simultaneous push and pop when full is not needed (credit prevents overflow), simultaneous push/pop otherwise SHALL keep count unchanged.
REQ-023 R outputs SHALL be stable while r_valid_o & !r_ready_i (AXI rule); r_id_o/r_user_o come from the FIFO entry, so a new AR may be accepted while prior beats drain.
REQ-024 mem_rvalid_i with outstanding = 0 is illegal and SHALL be ignored.
REQ-025 Throughput: zero-wait memory (grant same cycle, rvalid next cycle) and r_ready_i = 1 SHALL sustain one R beat per cycle.

Reset
REQ-026 With rst_i = 1 at a clock edge: FSM = IDLE, FIFO empty, outstanding = 0, counter = 0.
REQ-027 Output reset values: ar_ready_o = 1 after reset (IDLE), mem_req_o = 0, r_valid_o = 0, r_last_o = 0, r_resp_o = 0, r_data_o/r_id_o/r_user_o = 0.
REQ-028 Reset mid-burst SHALL discard all state; memory responses arriving after reset are ignored.

Structure
REQ-029 Shared package ext_ipa_pkg SHALL hold burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR) and the FSM state enum.
REQ-030 The 2-entry response FIFO SHALL be a sub-module ext_resp_fifo_ipa (valid/ready both sides, parametric width).

Verification
REQ-031 INCR: addr 0x100, len 3, size 3, mem rdata = addr -> 4 beats, data 0x100,0x108,0x110,0x118, id echoed, last on beat 4, resp OKAY.
REQ-032 WRAP: addr 0x118, len 3, size 3 -> mem_addr_o 0x118,0x100,0x108,0x110.
REQ-033 Backpressure: r_ready_i = 0 for 10 cycles during len 7 INCR -> at most 2 mem grants in flight/buffered, no lost or duplicated beat, outputs stable.
REQ-034 Errors: burst 2'b11, len 2 -> 3 SLVERR beats, data 0, no mem_req_o; mem_err_i on beat 2 of 4 -> only beat 2 SLVERR.
REQ-035 Back-to-back ARs id 1 then id 2 (len 0 each) -> R beats id 1 then id 2, each last = 1, 1 beat/cycle with zero-wait memory.
REQ-036 rst_i asserted mid-burst with 2 FIFO entries -> next cycle r_valid_o = 0, mem_req_o = 0, ar_ready_o = 1.

Source files
------------

// File: rtl/ext_ipa_pkg.sv
// Shared encodings for the AXI read responder: burst types, response codes
// and the responder FSM states.
package ext_ipa_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ERR
  } state_e;

endpackage

// File: rtl/ext_resp_fifo_ipa.sv
// Two-entry valid/ready FIFO holding complete R beats; the occupancy is
// exported so the responder can budget memory requests against it.
module ext_resp_fifo_ipa #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign push_ready_o = (count_q != 2'd2);
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_valid_o & pop_ready_i;

  // Storage is cleared on reset so the R outputs read as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ext_r_responder_ipa.sv
// AXI read responder: turns one AR burst into word-wide memory reads and
// returns the data as R beats through a two-entry response FIFO.
module ext_r_responder_ipa
  import ext_ipa_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [USER_WIDTH-1:0] ar_user_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [USER_WIDTH-1:0] r_user_o,
  output logic                  r_last_o
);

  localparam int BUS_LSB = $clog2(DATA_WIDTH / 8);
  localparam int TAG_W   = ID_WIDTH + USER_WIDTH + 1;
  localparam int ENTRY_W = ID_WIDTH + USER_WIDTH + DATA_WIDTH + 3;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              cnt_q;
  logic [1:0]              outst_q;
  logic [TAG_W-1:0]        tag_q [2];
  logic                    tag_wr_q;
  logic                    tag_rd_q;

  logic                    ar_accept;
  logic                    ar_bad;
  logic                    last_beat;
  logic                    issue;
  logic                    rsp_accept;
  logic                    err_push;
  logic                    pop;
  logic [2:0]              occupancy;
  logic [1:0]              fifo_count;
  logic                    push_valid;
  logic                    push_ready;
  logic [ENTRY_W-1:0]      push_data;
  logic [ENTRY_W-1:0]      pop_data;
  logic [TAG_W-1:0]        rsp_tag;
  logic [ADDR_WIDTH-1:0]   size_bytes;
  logic [ADDR_WIDTH-1:0]   incr_addr;
  logic [ADDR_WIDTH-1:0]   wrap_mask;
  logic [ADDR_WIDTH-1:0]   next_addr;

  assign ar_ready_o = (state_q == IDLE);
  assign ar_accept  = ar_valid_i & ar_ready_o;
  assign ar_bad     = (ar_burst_i == BURST_RSVD) ||
                      (int'(ar_size_i) > BUS_LSB) ||
                      ((ar_burst_i == BURST_WRAP) &&
                       !(ar_len_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign last_beat  = (cnt_q == len_q);

  // A beat leaving the FIFO this cycle frees its slot, which keeps zero-wait
  // memory streaming at one beat per cycle with only two entries of credit.
  assign pop        = r_valid_o & r_ready_i;
  assign occupancy  = {1'b0, fifo_count} + {1'b0, outst_q} - {2'b00, pop};
  assign mem_req_o  = (state_q == ISSUE) && (occupancy < 3'd2);
  assign issue      = mem_req_o & mem_gnt_i;
  assign rsp_accept = mem_rvalid_i && (outst_q != 2'd0);
  assign err_push   = (state_q == ERR) && (outst_q == 2'd0) && push_ready;
  assign mem_addr_o = {addr_q[ADDR_WIDTH-1:BUS_LSB], {BUS_LSB{1'b0}}};

  always_comb begin
    size_bytes = ADDR_WIDTH'(1) << size_q;
    incr_addr  = (addr_q & ~(size_bytes - ADDR_WIDTH'(1))) + size_bytes;
    wrap_mask  = (ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_valid_i) state_d = ar_bad ? ERR : ISSUE;
      ISSUE:   if (issue && last_beat) state_d = IDLE;
      ERR:     if (err_push && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q     <= '0;
      user_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
      tag_wr_q <= 1'b0;
      tag_rd_q <= 1'b0;
    end else begin
      if (ar_accept) begin
        id_q    <= ar_id_i;
        user_q  <= ar_user_i;
        addr_q  <= ar_addr_i;
        len_q   <= ar_len_i;
        size_q  <= ar_size_i;
        burst_q <= ar_burst_i;
        cnt_q   <= '0;
      end else if ((issue || err_push) && !last_beat) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= next_addr;
      end
      outst_q <= outst_q + 2'(issue) - 2'(rsp_accept);
      if (issue)      tag_wr_q <= ~tag_wr_q;
      if (rsp_accept) tag_rd_q <= ~tag_rd_q;
    end
  end

  // Each granted beat carries its own id/user/last, since a new AR may
  // overwrite the latched fields before the memory data returns.
  always_ff @(posedge clk_i) begin
    if (issue) tag_q[tag_wr_q] <= {id_q, user_q, last_beat};
  end

  always_comb begin
    rsp_tag    = tag_q[tag_rd_q];
    push_valid = rsp_accept || err_push;
    if (rsp_accept)
      push_data = {rsp_tag[TAG_W-1:1], mem_rdata_i,
                   mem_err_i ? RESP_SLVERR : RESP_OKAY, rsp_tag[0]};
    else
      push_data = {id_q, user_q, {DATA_WIDTH{1'b0}}, RESP_SLVERR, last_beat};
  end

  ext_resp_fifo_ipa #(
    .WIDTH(ENTRY_W)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_valid_i(push_valid),
    .push_ready_o(push_ready),
    .push_data_i (push_data),
    .pop_valid_o (r_valid_o),
    .pop_ready_i (r_ready_i),
    .pop_data_o  (pop_data),
    .count_o     (fifo_count)
  );

  assign {r_id_o, r_user_o, r_data_o, r_resp_o, r_last_o} = pop_data;

endmodule
